// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizing for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int DEF_BYTE_W  = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_MEM_TOP = 300;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: contention resolved by the pointer, which then
// moves to whichever port did not win.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant,
  output logic ptr
);

  logic r_ptr;
  logic w_grant;

  // A lone request wins outright; only a tie consults the pointer.
  always_comb begin
    w_grant = 1'b0;
    if (req0 && req1) begin
      w_grant = r_ptr;
    end else if (req1) begin
      w_grant = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (update && (req0 || req1)) begin
      r_ptr <= ~w_grant;
    end
  end

  assign grant = w_grant;
  assign ptr   = r_ptr;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a processor port and a debug port onto one word-wide data memory;
// each access takes IDLE -> BUSY -> DONE and is range-checked against MEM_TOP.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int BYTE_W  = DEF_BYTE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEM_TOP = DEF_MEM_TOP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [8*BYTE_W-1:0] wdata0,
  input  logic [8*BYTE_W-1:0] wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic                err0,
  output logic                err1,
  output logic [8*BYTE_W-1:0] rdata0,
  output logic [8*BYTE_W-1:0] rdata1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [8*BYTE_W-1:0] mem_data,
  output logic                mem_write_enable,
  input  logic [8*BYTE_W-1:0] mem_read_data
);

  localparam int DW = 8 * BYTE_W;
  localparam int XW = ADDR_W + 2;

  state_t          r_state;
  logic            r_owner;
  logic            r_ack0;
  logic            r_ack1;
  logic            r_err0;
  logic            r_err1;
  logic [DW-1:0]   r_rdata0;
  logic [DW-1:0]   r_rdata1;

  logic            w_grant;
  logic            w_rr_ptr_unused;
  logic            w_update;
  logic            w_busy;
  logic            w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [XW-1:0]   w_last_byte;
  logic            w_in_range;
  logic [DW-1:0]   w_rd_word;

  assign w_update = (r_state == ST_IDLE) && (req0 || req1);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .update (w_update),
    .grant  (w_grant),
    .ptr    (w_rr_ptr_unused)
  );

  assign w_busy      = (r_state == ST_BUSY);
  assign w_sel_we    = r_owner ? we1    : we0;
  assign w_sel_addr  = r_owner ? addr1  : addr0;
  assign w_sel_wdata = r_owner ? wdata1 : wdata0;

  // Widened by two bits so an access near the top of the address space
  // cannot wrap around and masquerade as in range.
  assign w_last_byte = {2'b00, w_sel_addr} + XW'(BYTE_W - 1);
  assign w_in_range  = (w_last_byte <= XW'(MEM_TOP));
  assign w_rd_word   = w_in_range ? mem_read_data : '0;

  assign mem_address      = w_busy ? w_sel_addr  : '0;
  assign mem_data         = w_busy ? w_sel_wdata : '0;
  assign mem_write_enable = w_busy & w_sel_we & w_in_range & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_err0 <= 1'b0;
          r_err1 <= 1'b0;
          if (req0 || req1) begin
            r_owner <= w_grant;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_state <= ST_DONE;
          if (r_owner) begin
            r_ack1 <= 1'b1;
            r_err1 <= ~w_in_range;
            if (!w_sel_we) r_rdata1 <= w_rd_word;
          end else begin
            r_ack0 <= 1'b1;
            r_err0 <= ~w_in_range;
            if (!w_sel_we) r_rdata0 <= w_rd_word;
          end
        end
        ST_DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign err0   = r_err0;
  assign err1   = r_err1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule
